tx_frame_arbiter: RTL

TX_FRAME_ARBITER -- requirements
Module: tx_frame_arbiter

---
 rtl/tx_arb_pkg.sv | 17 +
 rtl/tx_gap_timer.sv | 28 ++
 rtl/tx_frame_arbiter.sv | 160 ++++++++++++++++
 3 files changed

// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: state encoding and default parameters shared by the
// two-requester transmit frame arbiter and its helpers.
package tx_arb_pkg;

  localparam int D_DEF       = 8;
  localparam int GAP_DEF     = 16;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SEND,
    ST_WAIT_START,
    ST_WAIT_DONE,
    ST_GAP
  } state_t;

endpackage

// File: rtl/tx_gap_timer.sv
// tx_gap_timer: loadable down-counter, done while the count is zero.
// Used for the inter-frame gap and the optional SEND watchdog.
module tx_gap_timer #(
  parameter int W = 5
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] init,
  output logic         done
);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= init;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/tx_frame_arbiter.sv
// tx_frame_arbiter: round-robin frame arbiter for two byte requesters
// feeding one transmitter. Define TX_ARB_WATCHDOG_EN for the SEND watchdog.
module tx_frame_arbiter
  import tx_arb_pkg::*;
#(
  parameter int D       = D_DEF,
  parameter int GAP     = GAP_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic [1:0]   req,
  input  logic [1:0]   valid,
  input  logic [D-1:0] data0,
  input  logic [D-1:0] data1,
  input  logic [1:0]   last,
  input  logic         tx_rdy,
  output logic [1:0]   gnt,
  output logic [1:0]   ack,
  output logic         tx_send,
  output logic [D-1:0] tx_data,
  output logic         busy
`ifdef TX_ARB_WATCHDOG_EN
  ,
  output logic         abort
`endif
);

  // One counter width serves both the gap timer and the watchdog.
  localparam int CW = $clog2(((GAP > TIMEOUT) ? GAP : TIMEOUT) + 1);
  localparam logic [CW-1:0] GAP_LD = CW'(GAP - 1);

  state_t       state, state_n;
  logic         ptr, ptr_n;
  logic         sel, sel_n;
  logic         last_r, last_n;
  logic [1:0]   gnt_n, ack_n;
  logic         send_n;
  logic [D-1:0] data_n;
  logic         vg, lg;
  logic [D-1:0] dg;
  logic         gap_done;

  assign vg   = sel ? valid[1] : valid[0];
  assign lg   = sel ? last[1]  : last[0];
  assign dg   = sel ? data1    : data0;
  assign busy = (state != ST_IDLE);

  tx_gap_timer #(.W(CW)) u_gap (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (state != ST_GAP),
    .en      (state == ST_GAP),
    .init    (GAP_LD),
    .done    (gap_done)
  );

`ifdef TX_ARB_WATCHDOG_EN
  localparam logic [CW-1:0] TO_LD = CW'(TIMEOUT - 1);
  logic wd_run, wd_done, abort_n;

  assign wd_run = (state == ST_SEND) && !vg;

  tx_gap_timer #(.W(CW)) u_wd (
    .clk     (clk),
    .reset_n (reset_n),
    .load    (!wd_run),
    .en      (wd_run),
    .init    (TO_LD),
    .done    (wd_done)
  );
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state   <= ST_IDLE;
      ptr     <= 1'b0;
      sel     <= 1'b0;
      last_r  <= 1'b0;
      gnt     <= '0;
      ack     <= '0;
      tx_send <= 1'b0;
      tx_data <= '0;
`ifdef TX_ARB_WATCHDOG_EN
      abort   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      ptr     <= ptr_n;
      sel     <= sel_n;
      last_r  <= last_n;
      gnt     <= gnt_n;
      ack     <= ack_n;
      tx_send <= send_n;
      tx_data <= data_n;
`ifdef TX_ARB_WATCHDOG_EN
      abort   <= abort_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    sel_n   = sel;
    last_n  = last_r;
    gnt_n   = gnt;
    ack_n   = '0;
    send_n  = 1'b0;
    data_n  = tx_data;
`ifdef TX_ARB_WATCHDOG_EN
    abort_n = 1'b0;
`endif
    unique case (state)
      ST_IDLE: begin
        if (|req) begin
          sel_n   = (&req) ? ptr : req[1];
          gnt_n   = sel_n ? 2'b10 : 2'b01;
          state_n = ST_SEND;
        end
      end
      ST_SEND: begin
        if (vg && tx_rdy) begin
          send_n     = 1'b1;
          ack_n[sel] = 1'b1;
          data_n     = dg;
          last_n     = lg;
          state_n    = ST_WAIT_START;
        end
`ifdef TX_ARB_WATCHDOG_EN
        else if (!vg && wd_done) begin
          abort_n = 1'b1;
          gnt_n   = '0;
          ptr_n   = ~sel;
          state_n = ST_GAP;
        end
`endif
      end
      ST_WAIT_START: begin
        if (!tx_rdy) state_n = ST_WAIT_DONE;
      end
      ST_WAIT_DONE: begin
        if (tx_rdy) begin
          if (last_r) begin
            gnt_n   = '0;
            ptr_n   = ~sel;
            state_n = ST_GAP;
          end else begin
            state_n = ST_SEND;
          end
        end
      end
      ST_GAP: begin
        if (gap_done) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
